// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, reads opcode/immediate bytes over a
// ready/valid memory port, folds the CB prefix and handles HALT sleep/wake.
module fetch_unit #(
  parameter logic [15:0] RESET_PC  = 16'h0000,
  parameter logic [7:0]  CB_PREFIX = 8'hCB
) (
  input  logic        clk,
  input  logic        rst,
  output logic [15:0] mem_addr,
  output logic        mem_rd_en,
  input  logic [7:0]  mem_rd_data,
  input  logic        mem_ready,
  output logic [7:0]  curr_op,
  output logic        op_cb,
  output logic        op_valid,
  input  logic        op_done,
  input  logic        imm_req,
  output logic [7:0]  imm_data,
  output logic        imm_valid,
  input  logic        pc_load,
  input  logic [15:0] pc_load_val,
  input  logic        halt_req,
  input  logic        wake,
  output logic [15:0] pc
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_FETCH_CB,
    S_ISSUE,
    S_IMM,
    S_HALTED
  } state_t;

  state_t state;

  assign mem_addr = pc;

  // mem_rd_en and op_valid are registered decodes of the state being entered
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      pc        <= RESET_PC;
      curr_op   <= 8'h00;
      op_cb     <= 1'b0;
      op_valid  <= 1'b0;
      imm_data  <= 8'h00;
      imm_valid <= 1'b0;
      mem_rd_en <= 1'b0;
    end else begin
      imm_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          state     <= S_FETCH;
          mem_rd_en <= 1'b1;
        end
        S_FETCH: begin
          if (mem_ready) begin
            curr_op <= mem_rd_data;
            pc      <= pc + 16'd1;
            if (mem_rd_data == CB_PREFIX) begin
              op_cb <= 1'b1;
              state <= S_FETCH_CB;
            end else begin
              op_cb     <= 1'b0;
              state     <= S_ISSUE;
              mem_rd_en <= 1'b0;
              op_valid  <= 1'b1;
            end
          end
        end
        S_FETCH_CB: begin
          // second byte is taken verbatim, even if it is another prefix
          if (mem_ready) begin
            curr_op   <= mem_rd_data;
            pc        <= pc + 16'd1;
            state     <= S_ISSUE;
            mem_rd_en <= 1'b0;
            op_valid  <= 1'b1;
          end
        end
        S_ISSUE: begin
          if (pc_load) begin
            pc <= pc_load_val;
          end
          if (op_done && halt_req) begin
            state    <= S_HALTED;
            op_valid <= 1'b0;
          end else if (op_done) begin
            state     <= S_FETCH;
            op_valid  <= 1'b0;
            mem_rd_en <= 1'b1;
          end else if (imm_req) begin
            state     <= S_IMM;
            op_valid  <= 1'b0;
            mem_rd_en <= 1'b1;
          end
        end
        S_IMM: begin
          if (mem_ready) begin
            imm_data  <= mem_rd_data;
            imm_valid <= 1'b1;
            pc        <= pc + 16'd1;
            state     <= S_ISSUE;
            mem_rd_en <= 1'b0;
            op_valid  <= 1'b1;
          end
        end
        S_HALTED: begin
          if (wake) begin
            state     <= S_FETCH;
            mem_rd_en <= 1'b1;
          end
        end
        default: begin
          state     <= S_IDLE;
          mem_rd_en <= 1'b0;
          op_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed scenarios followed by a randomized program
// walk checked against a byte-level model of instruction/immediate fetching.
module tb_fetch_unit;

  logic        clk;
  logic        rst;
  logic [15:0] mem_addr;
  logic        mem_rd_en;
  logic [7:0]  mem_rd_data;
  logic        mem_ready;
  logic [7:0]  curr_op;
  logic        op_cb;
  logic        op_valid;
  logic        op_done;
  logic        imm_req;
  logic [7:0]  imm_data;
  logic        imm_valid;
  logic        pc_load;
  logic [15:0] pc_load_val;
  logic        halt_req;
  logic        wake;
  logic [15:0] pc;

  logic [7:0] mem [65536];
  logic       ready_rand;
  logic       ready_fixed;
  logic       rnd_bit;

  int n_cmp;
  int n_bad;

  fetch_unit dut (
    .clk(clk), .rst(rst), .mem_addr(mem_addr), .mem_rd_en(mem_rd_en),
    .mem_rd_data(mem_rd_data), .mem_ready(mem_ready), .curr_op(curr_op),
    .op_cb(op_cb), .op_valid(op_valid), .op_done(op_done), .imm_req(imm_req),
    .imm_data(imm_data), .imm_valid(imm_valid), .pc_load(pc_load),
    .pc_load_val(pc_load_val), .halt_req(halt_req), .wake(wake), .pc(pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rd_data = mem[mem_addr];
  assign mem_ready   = ready_rand ? rnd_bit : ready_fixed;

  always @(negedge clk) rnd_bit = ($urandom_range(0, 2) != 0);

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Model: one instruction starting at address a, CB folded into a flag
  task automatic predict(input logic [15:0] a, output logic [7:0] op,
                         output logic cb, output logic [15:0] nxt);
    if (mem[a] == 8'hCB) begin
      op  = mem[a + 16'd1];
      cb  = 1'b1;
      nxt = a + 16'd2;
    end else begin
      op  = mem[a];
      cb  = 1'b0;
      nxt = a + 16'd1;
    end
  endtask

  task automatic wait_op(input string tag, output int n, output bit saw_imm);
    n = 0;
    saw_imm = 1'b0;
    while (op_valid !== 1'b1 && n < 64) begin
      tick();
      if (imm_valid === 1'b1) saw_imm = 1'b1;
      n++;
    end
    check(tag, 32'(op_valid), 32'd1);
  endtask

  task automatic expect_op(input string tag, input logic [15:0] a, output logic [15:0] nxt);
    logic [7:0] op;
    logic       cb;
    int         n;
    bit         saw;
    predict(a, op, cb, nxt);
    wait_op({tag, "_wait"}, n, saw);
    check({tag, "_op"}, 32'(curr_op), 32'(op));
    check({tag, "_cb"}, 32'(op_cb), 32'(cb));
    check({tag, "_pc"}, 32'(pc), 32'(nxt));
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_pc"}, 32'(pc), 32'h0000);
    check({tag, "_addr"}, 32'(mem_addr), 32'h0000);
    check({tag, "_rden"}, 32'(mem_rd_en), 32'd0);
    check({tag, "_op"}, 32'(curr_op), 32'h00);
    check({tag, "_cb"}, 32'(op_cb), 32'd0);
    check({tag, "_opv"}, 32'(op_valid), 32'd0);
    check({tag, "_imm"}, 32'(imm_data), 32'h00);
    check({tag, "_immv"}, 32'(imm_valid), 32'd0);
  endtask

  initial begin
    logic [15:0] nxt;
    logic [15:0] pc_m;
    logic [15:0] lv;
    logic [7:0]  op;
    logic        cb;
    int          n;
    int          r;
    int          k;
    bit          saw;

    n_cmp = 0;
    n_bad = 0;
    rst = 1'b0;
    op_done = 1'b0;
    imm_req = 1'b0;
    pc_load = 1'b0;
    pc_load_val = 16'h0000;
    halt_req = 1'b0;
    wake = 1'b0;
    ready_rand = 1'b0;
    ready_fixed = 1'b1;
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    mem[0] = 8'h3E;
    mem[1] = 8'h42;
    mem[2] = 8'h00;

    // Reset state, opcode + immediate + next opcode
    tick();
    tick();
    check_reset_outputs("rst");
    rst = 1'b1;
    tick();
    check("first_rden", 32'(mem_rd_en), 32'd1);
    check("first_addr", 32'(mem_addr), 32'h0000);
    wait_op("t1_wait", n, saw);
    check("t1_lat", 32'(n), 32'd1);
    check("t1_op", 32'(curr_op), 32'h3E);
    check("t1_cb", 32'(op_cb), 32'd0);
    check("t1_pc", 32'(pc), 32'h0001);
    imm_req = 1'b1;
    tick();
    imm_req = 1'b0;
    check("imm_opv", 32'(op_valid), 32'd0);
    check("imm_rden", 32'(mem_rd_en), 32'd1);
    check("imm_addr", 32'(mem_addr), 32'h0001);
    tick();
    check("imm_v", 32'(imm_valid), 32'd1);
    check("imm_d", 32'(imm_data), 32'h42);
    check("imm_pc", 32'(pc), 32'h0002);
    check("imm_hold_op", 32'(curr_op), 32'h3E);
    check("imm_opv2", 32'(op_valid), 32'd1);
    tick();
    check("imm_pulse", 32'(imm_valid), 32'd0);
    check("imm_held", 32'(imm_data), 32'h42);
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    expect_op("t1b", 16'h0002, nxt);

    // CB prefix folding: 0xCB never presented on its own
    rst = 1'b0;
    tick();
    mem[0] = 8'hCB;
    mem[1] = 8'h37;
    mem[2] = 8'h5A;
    rst = 1'b1;
    tick();
    wait_op("cb_wait", n, saw);
    check("cb_lat", 32'(n), 32'd2);
    check("cb_op", 32'(curr_op), 32'h37);
    check("cb_flag", 32'(op_cb), 32'd1);
    check("cb_pc", 32'(pc), 32'h0002);

    // Three wait states; pc_load outside ISSUE must be ignored
    ready_fixed = 1'b0;
    op_done = 1'b1;
    tick();
    op_done = 1'b0;
    pc_load = 1'b1;
    pc_load_val = 16'h1234;
    for (int i = 0; i < 4; i++) begin
      check("stall_rden", 32'(mem_rd_en), 32'd1);
      check("stall_addr", 32'(mem_addr), 32'h0002);
      check("stall_opv", 32'(op_valid), 32'd0);
      if (i == 3) ready_fixed = 1'b1;
      tick();
    end
    pc_load = 1'b0;
    check("stall_done", 32'(op_valid), 32'd1);
    check("stall_op", 32'(curr_op), 32'h5A);
    check("stall_pc", 32'(pc), 32'h0003);

    // Jump to 0xFFFF with wrap on increment
    mem[16'hFFFF] = 8'h00;
    pc_load = 1'b1;
    pc_load_val = 16'hFFFF;
    op_done = 1'b1;
    tick();
    pc_load = 1'b0;
    op_done = 1'b0;
    check("wrap_addr", 32'(mem_addr), 32'hFFFF);
    check("wrap_rden", 32'(mem_rd_en), 32'd1);
    expect_op("wrap", 16'hFFFF, nxt);

    // HALT then wake
    op_done = 1'b1;
    halt_req = 1'b1;
    tick();
    op_done = 1'b0;
    halt_req = 1'b0;
    for (int i = 0; i < 10; i++) begin
      check("halt_rden", 32'(mem_rd_en), 32'd0);
      check("halt_opv", 32'(op_valid), 32'd0);
      check("halt_pc", 32'(pc), 32'h0000);
      tick();
    end
    wake = 1'b1;
    tick();
    wake = 1'b0;
    check("wake_rden", 32'(mem_rd_en), 32'd1);
    check("wake_addr", 32'(mem_addr), 32'h0000);
    expect_op("wake", 16'h0000, nxt);

    // Asynchronous reset in the middle of a stalled read at 0x0010
    mem[16'h0010] = 8'h77;
    ready_fixed = 1'b0;
    pc_load = 1'b1;
    pc_load_val = 16'h0010;
    op_done = 1'b1;
    tick();
    pc_load = 1'b0;
    op_done = 1'b0;
    check("mid_addr", 32'(mem_addr), 32'h0010);
    check("mid_rden", 32'(mem_rd_en), 32'd1);
    #2 rst = 1'b0;
    #1 check_reset_outputs("async");
    tick();
    ready_fixed = 1'b1;
    rst = 1'b1;
    tick();
    check("rel_addr", 32'(mem_addr), 32'h0000);
    check("rel_rden", 32'(mem_rd_en), 32'd1);
    expect_op("rel", 16'h0000, nxt);

    // Randomized program walk with random memory wait states
    for (int i = 0; i < 65536; i++)
      mem[i] = ($urandom_range(0, 5) == 0) ? 8'hCB : 8'($urandom);
    rst = 1'b0;
    tick();
    ready_rand = 1'b1;
    rst = 1'b1;
    pc_m = 16'h0000;
    for (int it = 0; it < 150; it++) begin
      predict(pc_m, op, cb, nxt);
      wait_op("rnd_wait", n, saw);
      check("rnd_no_imm", 32'(saw), 32'd0);
      check("rnd_op", 32'(curr_op), 32'(op));
      check("rnd_cb", 32'(op_cb), 32'(cb));
      check("rnd_pc", 32'(pc), 32'(nxt));
      pc_m = nxt;
      k = $urandom_range(0, 2);
      for (int j = 0; j < k; j++) begin
        imm_req = 1'b1;
        tick();
        imm_req = 1'b0;
        n = 0;
        while (imm_valid !== 1'b1 && n < 64) begin
          tick();
          n++;
        end
        check("rnd_immv", 32'(imm_valid), 32'd1);
        check("rnd_immd", 32'(imm_data), 32'(mem[pc_m]));
        pc_m = pc_m + 16'd1;
        check("rnd_imm_pc", 32'(pc), 32'(pc_m));
        check("rnd_imm_op", 32'(curr_op), 32'(op));
      end
      if ($urandom_range(0, 5) == 0) begin
        lv = 16'($urandom);
        pc_load = 1'b1;
        pc_load_val = lv;
        tick();
        pc_load = 1'b0;
        pc_m = lv;
        check("rnd_load_pc", 32'(pc), 32'(pc_m));
        check("rnd_load_opv", 32'(op_valid), 32'd1);
      end
      r = $urandom_range(0, 15);
      if (r == 0) begin
        op_done = 1'b1;
        halt_req = 1'b1;
        tick();
        op_done = 1'b0;
        halt_req = 1'b0;
        k = $urandom_range(1, 6);
        for (int j = 0; j < k; j++) begin
          check("rnd_halt_rden", 32'(mem_rd_en), 32'd0);
          check("rnd_halt_pc", 32'(pc), 32'(pc_m));
          tick();
        end
        wake = 1'b1;
        tick();
        wake = 1'b0;
      end else begin
        if (r < 5) begin
          lv = 16'($urandom);
          pc_load = 1'b1;
          pc_load_val = lv;
          pc_m = lv;
        end
        if (r >= 5 && r < 9) imm_req = 1'b1;
        op_done = 1'b1;
        tick();
        op_done = 1'b0;
        imm_req = 1'b0;
        pc_load = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
